// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: lets NREQ requesters share the write port of one synchronous FIFO.
// In IDLE a round-robin scan picks the next requester. If that requester's first word
// is not its last, it owns the port in BURST until it marks last or reaches MAX_BURST
// words. Grant, write enable and write data are combinational, so an accepted word
// reaches the FIFO in the same cycle.
// Handshake: req[k] is valid and gnt[k] is ready. Word k moves on any cycle where both
// are high; gnt never rises while full is high. The owner and pointer registers are
// two bits wide, so NREQ must be 4 or less.
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DW        = 10,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    last,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic               full,
    output logic [NREQ-1:0]    gnt,
    output logic               w_enable,
    output logic [DW-1:0]      wr_data,
    output logic               busy,
    output logic [1:0]         owner,
    output logic [15:0]        wr_count,
    output logic               dbg_state,
    output logic [1:0]         dbg_rr_ptr,
    output logic [3:0]         dbg_beat_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t          state;
    logic [1:0]      rr_ptr;
    logic [3:0]      beat_cnt;
    logic [1:0]      sel;
    logic            any_req;
    logic [NREQ-1:0] gnt_c;

    // Advances a requester index by one, wrapping at NREQ.
    function automatic logic [1:0] inc_mod(input logic [1:0] v);
        if (int'(v) == NREQ - 1) return 2'd0;
        return v + 2'd1;
    endfunction

    // Round-robin scan: the first requesting index at or after rr_ptr wins.
    always_comb begin
        int idx;
        any_req = 1'b0;
        sel     = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                sel     = 2'(idx);
            end
        end
    end

    // Grant: scan winner in IDLE, the locked owner in BURST; nothing while full or in reset.
    always_comb begin
        gnt_c = '0;
        if (reset && !full) begin
            if (state == IDLE) begin
                if (any_req) gnt_c[sel] = 1'b1;
            end else begin
                gnt_c[owner] = 1'b1;
            end
        end
    end

    // Steers the granted requester's data onto the FIFO bus; zero when nobody is granted.
    always_comb begin
        wr_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt_c[k]) wr_data = req_data[k*DW +: DW];
        end
    end

    assign gnt          = gnt_c;
    assign w_enable     = |(gnt_c & req);
    assign busy         = (state == BURST);
    assign dbg_state    = state;
    assign dbg_rr_ptr   = rr_ptr;
    assign dbg_beat_cnt = beat_cnt;

    // Arbitration FSM: every state, pointer and counter change is tied to an accepted word,
    // so a full FIFO or a silent owner freezes everything.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            rr_ptr   <= 2'd0;
            owner    <= 2'd0;
            beat_cnt <= 4'd0;
            wr_count <= 16'd0;
        end else if (w_enable) begin
            wr_count <= wr_count + 16'd1;
            if (state == IDLE) begin
                owner <= sel;
                if (last[sel] || MAX_BURST == 1) begin
                    rr_ptr <= inc_mod(sel);
                end else begin
                    state    <= BURST;
                    beat_cnt <= 4'd1;
                end
            end else begin
                beat_cnt <= beat_cnt + 4'd1;
                if (last[owner] || (beat_cnt + 4'd1) == 4'(MAX_BURST)) begin
                    state  <= IDLE;
                    rr_ptr <= inc_mod(owner);
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter at default parameters (NREQ=4, DW=10, MAX_BURST=4).
// Inputs change 1 ns after a rising edge; outputs are checked mid-cycle.
module tb_fifo_wr_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 10;

    logic               clk;
    logic               reset;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    last;
    logic [NREQ*DW-1:0] req_data;
    logic               full;
    logic [NREQ-1:0]    gnt;
    logic               w_enable;
    logic [DW-1:0]      wr_data;
    logic               busy;
    logic [1:0]         owner;
    logic [15:0]        wr_count;
    logic               dbg_state;
    logic [1:0]         dbg_rr_ptr;
    logic [3:0]         dbg_beat_cnt;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0]   dval [NREQ];
    logic [NREQ-1:0] exp_q [$];
    logic [DW-1:0]   exp_d [$];

    fifo_wr_arbiter #(.NREQ(4), .DW(10), .MAX_BURST(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .last         (last),
        .req_data     (req_data),
        .full         (full),
        .gnt          (gnt),
        .w_enable     (w_enable),
        .wr_data      (wr_data),
        .busy         (busy),
        .owner        (owner),
        .wr_count     (wr_count),
        .dbg_state    (dbg_state),
        .dbg_rr_ptr   (dbg_rr_ptr),
        .dbg_beat_cnt (dbg_beat_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle where only the grant path is checked, then the edge is taken.
    task automatic grant_cycle(input string tag, input logic [NREQ-1:0] exp_gnt,
                               input logic exp_we);
        #4;
        check({tag, "_gnt"}, 32'(gnt), 32'(exp_gnt));
        check({tag, "_we"}, 32'(w_enable), 32'(exp_we));
        tick();
    endtask

    // Invariants: at most one grant, never write into a full FIFO.
    always @(negedge clk) begin
        if (reset) begin
            check("onehot", 32'($onehot0(gnt)), 32'd1);
            check("we_full", 32'(w_enable & full), 32'd0);
        end
    end

    initial begin
        dval[0] = 10'd5;
        dval[1] = 10'd42;
        dval[2] = 10'd79;
        dval[3] = 10'd116;
        for (int k = 0; k < NREQ; k++) req_data[k*DW +: DW] = dval[k];

        // Reset held with everybody requesting: outputs stay quiet.
        reset = 1'b0;
        req   = 4'b1111;
        last  = 4'b1111;
        full  = 1'b0;
        #12;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_we", 32'(w_enable), 32'd0);
        check("rst_data", 32'(wr_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_count", 32'(wr_count), 32'd0);
        tick();
        reset = 1'b1;

        // All requesting single words: rotating grants 0,1,2,3,0.
        exp_q.push_back(4'b0001); exp_d.push_back(10'd5);
        exp_q.push_back(4'b0010); exp_d.push_back(10'd42);
        exp_q.push_back(4'b0100); exp_d.push_back(10'd79);
        exp_q.push_back(4'b1000); exp_d.push_back(10'd116);
        exp_q.push_back(4'b0001); exp_d.push_back(10'd5);
        for (int n = 0; n < 5; n++) begin
            logic [NREQ-1:0] eg;
            logic [DW-1:0]   ed;
            eg = exp_q.pop_front();
            ed = exp_d.pop_front();
            #4;
            check("rr_gnt", 32'(gnt), 32'(eg));
            check("rr_data", 32'(wr_data), 32'(ed));
            check("rr_busy", 32'(busy), 32'd0);
            tick();
            if (n == 3) check("rr_count4", 32'(wr_count), 32'd4);
        end
        req = 4'b0000;
        check("rr_count5", 32'(wr_count), 32'd5);
        check("rr_ptr1", 32'(dbg_rr_ptr), 32'd1);

        // Lone requester 2 without last: burst capped at 4 words.
        req  = 4'b0100;
        last = 4'b0000;
        #4;
        check("b4_busy1", 32'(busy), 32'd0);
        check("b4_gnt1", 32'(gnt), 32'b0100);
        check("b4_data1", 32'(wr_data), 32'd79);
        tick();
        for (int n = 2; n <= 4; n++) begin
            #4;
            check("b4_busy", 32'(busy), 32'd1);
            check("b4_gnt", 32'(gnt), 32'b0100);
            tick();
        end
        req = 4'b0000;
        check("b4_state", 32'(dbg_state), 32'd0);
        check("b4_rr", 32'(dbg_rr_ptr), 32'd3);
        check("b4_owner", 32'(owner), 32'd2);
        check("b4_count", 32'(wr_count), 32'd9);

        // Owner 1 locked in while 0 and 3 request; then 3 and 0 follow.
        req  = 4'b0010;
        last = 4'b0000;
        grant_cycle("lk1", 4'b0010, 1'b1);
        req = 4'b1011;
        grant_cycle("lk2", 4'b0010, 1'b1);
        last = 4'b0010;
        grant_cycle("lk3", 4'b0010, 1'b1);
        check("lk_rr", 32'(dbg_rr_ptr), 32'd2);
        last = 4'b1111;
        grant_cycle("lk_nxt3", 4'b1000, 1'b1);
        grant_cycle("lk_nxt0", 4'b0001, 1'b1);
        req = 4'b0000;
        check("lk_count", 32'(wr_count), 32'd14);

        // FIFO full for three cycles in the middle of a burst.
        req  = 4'b0100;
        last = 4'b0000;
        grant_cycle("fu1", 4'b0100, 1'b1);
        grant_cycle("fu2", 4'b0100, 1'b1);
        full = 1'b1;
        for (int n = 0; n < 3; n++) begin
            #4;
            check("fu_gnt", 32'(gnt), 32'd0);
            check("fu_we", 32'(w_enable), 32'd0);
            check("fu_busy", 32'(busy), 32'd1);
            check("fu_beat", 32'(dbg_beat_cnt), 32'd2);
            check("fu_count", 32'(wr_count), 32'd16);
            tick();
        end
        full = 1'b0;
        grant_cycle("fu3", 4'b0100, 1'b1);
        grant_cycle("fu4", 4'b0100, 1'b1);
        req = 4'b0000;
        check("fu_state", 32'(dbg_state), 32'd0);
        check("fu_rr", 32'(dbg_rr_ptr), 32'd3);
        check("fu_count_end", 32'(wr_count), 32'd18);

        // Full while idle: no grant and nothing moves.
        req  = 4'b1111;
        full = 1'b1;
        grant_cycle("fi", 4'b0000, 1'b0);
        check("fi_rr", 32'(dbg_rr_ptr), 32'd3);
        full = 1'b0;
        req  = 4'b0000;

        // Owner 0 goes quiet for five cycles: port stays locked, others starve.
        req  = 4'b0001;
        last = 4'b0000;
        grant_cycle("st1", 4'b0001, 1'b1);
        req = 4'b1110;
        for (int n = 0; n < 5; n++) begin
            #4;
            check("st_gnt", 32'(gnt), 32'b0001);
            check("st_we", 32'(w_enable), 32'd0);
            check("st_busy", 32'(busy), 32'd1);
            check("st_beat", 32'(dbg_beat_cnt), 32'd1);
            check("st_count", 32'(wr_count), 32'd19);
            tick();
        end
        req  = 4'b0001;
        last = 4'b0001;
        grant_cycle("st_end", 4'b0001, 1'b1);
        req = 4'b0000;
        check("st_state", 32'(dbg_state), 32'd0);
        check("st_rr", 32'(dbg_rr_ptr), 32'd1);
        check("st_count_end", 32'(wr_count), 32'd20);

        // Reset pulsed during beat 2 of a burst.
        req  = 4'b0100;
        last = 4'b0000;
        grant_cycle("rb1", 4'b0100, 1'b1);
        #4;
        check("rb2_gnt", 32'(gnt), 32'b0100);
        reset = 1'b0;
        #1;
        check("rb_gnt", 32'(gnt), 32'd0);
        check("rb_we", 32'(w_enable), 32'd0);
        check("rb_data", 32'(wr_data), 32'd0);
        check("rb_busy", 32'(busy), 32'd0);
        check("rb_count", 32'(wr_count), 32'd0);
        check("rb_state", 32'(dbg_state), 32'd0);
        #5;
        reset = 1'b1;
        req   = 4'b1010;
        last  = 4'b1010;
        #3;
        check("rb_first_gnt", 32'(gnt), 32'b0010);
        check("rb_first_data", 32'(wr_data), 32'd42);
        tick();
        req = 4'b0000;
        check("rb_owner", 32'(owner), 32'd1);
        check("rb_count1", 32'(wr_count), 32'd1);
        check("rb_rr", 32'(dbg_rr_ptr), 32'd2);

        #4;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
